// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: shared types for the FIR tap scheduler.
// Holds the FSM state enum, exception flag bundle and a tap-count legality check.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } fir_state_e;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic invalid;
  } exc_flags_t;

  function automatic bit taps_legal(input int ntaps,
                                    input int haw,
                                    input int xaw);
    return (ntaps >= 1) &&
           (ntaps <= (1 << haw)) &&
           (ntaps <= (1 << xaw));
  endfunction

endpackage

// File: rtl/fir_tap_scheduler_exc.sv
// fir_exc_collector: gathers DSP58 exception flags for each output.
// Ports: pass_start_i/collect_i/out_valid_i from the FSM, clr_i, flags_i in, flags_o out.
// Macro FIR_EXC_STICKY_EN: sticky flags cleared only by clr_i (set wins).
module fir_exc_collector
  import fir_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pass_start_i,
  input  logic       collect_i,
  input  logic       out_valid_i,
  input  logic       clr_i,
  input  exc_flags_t flags_i,
  output exc_flags_t flags_o
);

  exc_flags_t flags_q;

`ifdef FIR_EXC_STICKY_EN

  logic unused_ok;
  assign unused_ok = ^{pass_start_i, collect_i, out_valid_i};

  // A flag arriving alongside clr_i survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        flags_q <= '0;
    else if (clr_i) flags_q <= flags_i;
    else            flags_q <= flags_q | flags_i;
  end

  assign flags_o = flags_q;

`else

  logic unused_ok;
  assign unused_ok = clr_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               flags_q <= '0;
    else if (pass_start_i) flags_q <= '0;
    else if (collect_i)    flags_q <= flags_q | flags_i;
  end

  assign flags_o = out_valid_i ? flags_q : '0;

`endif

endmodule

// File: rtl/fir_tap_scheduler.sv
// fir_tap_scheduler: one MAC pass per accepted sample over a circular X buffer.
// Ports: sample handshake, X RAM write, H/X RAM read, DSP58 first/last,
// output handshake, busy, exception flags. Macro FIR_EXC_STICKY_EN selects sticky flags.
module fir_tap_scheduler
  import fir_ctrl_pkg::*;
#(
  parameter int H_ADDR_WIDTH = 4,
  parameter int X_ADDR_WIDTH = 6,
  parameter int NUM_TAPS     = 16,
  parameter int DSP_LAT      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic                    x_wr_en_o,
  output logic [X_ADDR_WIDTH-1:0] x_wr_addr_o,
  output logic                    R_en,
  output logic [H_ADDR_WIDTH-1:0] h_addr,
  output logic [X_ADDR_WIDTH-1:0] x_addr,
  output logic                    acc_first_o,
  output logic                    acc_last_o,
  output logic                    y_valid_o,
  input  logic                    y_ready_i,
  output logic                    busy_o,
  input  logic                    overflow_i,
  input  logic                    underflow_i,
  input  logic                    invalid_i,
  output logic                    overflow_o,
  output logic                    underflow_o,
  output logic                    invalid_o,
  input  logic                    clr_flags_i
);

  localparam int DW = (DSP_LAT > 1) ? $clog2(DSP_LAT) : 1;
  localparam logic [H_ADDR_WIDTH-1:0] K_LAST =
    H_ADDR_WIDTH'(NUM_TAPS - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DSP_LAT - 1);

  if (!taps_legal(NUM_TAPS, H_ADDR_WIDTH, X_ADDR_WIDTH) ||
      (DSP_LAT < 1)) begin : g_bad_cfg
    $error("fir_tap_scheduler: illegal NUM_TAPS or DSP_LAT");
  end

  fir_state_e              state_q;
  logic [X_ADDR_WIDTH-1:0] wr_ptr_q;
  logic [X_ADDR_WIDTH-1:0] newest_q;
  logic [H_ADDR_WIDTH-1:0] k_q;
  logic [DW-1:0]           drain_q;
  logic                    r_en_q;
  logic [H_ADDR_WIDTH-1:0] h_addr_q;
  logic [X_ADDR_WIDTH-1:0] x_addr_q;
  logic                    first_q;
  logic                    last_q;
  logic                    y_valid_q;

  logic                    accept;
  logic [H_ADDR_WIDTH-1:0] k_d;

  assign accept = s_valid_i && (state_q == IDLE);
  assign k_d    = k_q + 1'b1;

  // Registered outputs are loaded one cycle ahead so they line up
  // with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      newest_q  <= '0;
      k_q       <= '0;
      drain_q   <= '0;
      r_en_q    <= 1'b0;
      h_addr_q  <= '0;
      x_addr_q  <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      y_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            newest_q <= wr_ptr_q;
            k_q      <= '0;
            r_en_q   <= 1'b1;
            h_addr_q <= '0;
            x_addr_q <= wr_ptr_q;
            first_q  <= 1'b1;
            last_q   <= (K_LAST == '0);
            state_q  <= MAC;
          end
        end
        MAC: begin
          if (k_q == K_LAST) begin
            k_q     <= '0;
            r_en_q  <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            drain_q <= '0;
            state_q <= DRAIN;
          end else begin
            k_q      <= k_d;
            h_addr_q <= k_d;
            x_addr_q <= newest_q - X_ADDR_WIDTH'(k_d);
            first_q  <= 1'b0;
            last_q   <= (k_d == K_LAST);
          end
        end
        DRAIN: begin
          if (drain_q == D_LAST) begin
            drain_q   <= '0;
            y_valid_q <= 1'b1;
            state_q   <= OUT;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        OUT: begin
          if (y_ready_i) begin
            y_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready_o   = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign x_wr_en_o   = accept;
  assign x_wr_addr_o = wr_ptr_q;
  assign R_en        = r_en_q;
  assign h_addr      = h_addr_q;
  assign x_addr      = x_addr_q;
  assign acc_first_o = first_q;
  assign acc_last_o  = last_q;
  assign y_valid_o   = y_valid_q;

  exc_flags_t flg_in;
  exc_flags_t flg_out;

  assign flg_in = '{overflow:  overflow_i,
                    underflow: underflow_i,
                    invalid:   invalid_i};

  fir_exc_collector u_exc (
    .clk          (clk),
    .rst          (rst),
    .pass_start_i (accept),
    .collect_i    ((state_q == MAC) || (state_q == DRAIN)),
    .out_valid_i  (y_valid_q),
    .clr_i        (clr_flags_i),
    .flags_i      (flg_in),
    .flags_o      (flg_out)
  );

  assign overflow_o  = flg_out.overflow;
  assign underflow_o = flg_out.underflow;
  assign invalid_o   = flg_out.invalid;

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// tb_fir_tap_scheduler: randomized self-checking bench for fir_tap_scheduler.
// Expected outputs come from a per-pass timeline model.
module tb_fir_tap_scheduler;

  localparam int N  = 16;
  localparam int L  = 4;
  localparam int HW = 4;
  localparam int XW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid_i;
  logic          s_ready_o;
  logic          x_wr_en_o;
  logic [XW-1:0] x_wr_addr_o;
  logic          R_en;
  logic [HW-1:0] h_addr;
  logic [XW-1:0] x_addr;
  logic          acc_first_o;
  logic          acc_last_o;
  logic          y_valid_o;
  logic          y_ready_i;
  logic          busy_o;
  logic          overflow_i, underflow_i, invalid_i;
  logic          overflow_o, underflow_o, invalid_o;
  logic          clr_flags_i;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            m_wp  = 0;
  logic [2:0]    m_sticky = 3'b000;

  localparam logic [25:0] RST_VEC = 26'h1 << 25;

  always #5 clk = ~clk;

  fir_tap_scheduler #(
    .H_ADDR_WIDTH(HW), .X_ADDR_WIDTH(XW),
    .NUM_TAPS(N), .DSP_LAT(L)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .x_wr_en_o(x_wr_en_o), .x_wr_addr_o(x_wr_addr_o),
    .R_en(R_en), .h_addr(h_addr), .x_addr(x_addr),
    .acc_first_o(acc_first_o), .acc_last_o(acc_last_o),
    .y_valid_o(y_valid_o), .y_ready_i(y_ready_i),
    .busy_o(busy_o),
    .overflow_i(overflow_i), .underflow_i(underflow_i),
    .invalid_i(invalid_i),
    .overflow_o(overflow_o), .underflow_o(underflow_o),
    .invalid_o(invalid_o),
    .clr_flags_i(clr_flags_i)
  );

  function automatic logic [25:0] outs();
    return {s_ready_o, x_wr_en_o, x_wr_addr_o, R_en, h_addr,
            x_addr, acc_first_o, acc_last_o, y_valid_o, busy_o,
            overflow_o, underflow_o, invalid_o};
  endfunction

  task automatic idle_inputs();
    s_valid_i   = 1'b0;
    y_ready_i   = 1'b0;
    overflow_i  = 1'b0;
    underflow_i = 1'b0;
    invalid_i   = 1'b0;
    clr_flags_i = 1'b0;
  endtask

  // One complete pass: accept at c=0, handshake at the last c.
  task automatic test_pass(input int d, input int p,
                           input logic [2:0] pb, input bit hold,
                           input string tag);
    int total;
    logic [2:0] acc;
    logic [25:0] exp, mask;
    logic ren, yv;
    logic [2:0] fl;
    total = N + L + 2 + d;
    acc = 3'b000;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      s_valid_i   = hold || (c == 0);
      y_ready_i   = (c == total - 1);
      {overflow_i, underflow_i, invalid_i} = (c == p) ? pb : 3'b000;
      clr_flags_i = 1'b0;
      #1;
      ren = (c >= 1) && (c <= N);
      yv  = (c > N + L);
`ifdef FIR_EXC_STICKY_EN
      fl = m_sticky;
`else
      fl = yv ? acc : 3'b000;
`endif
      exp = {(c == 0), (c == 0), XW'(m_wp), ren, HW'(c - 1),
             XW'(m_wp - (c - 1)), (c == 1), (c == N), yv,
             (c > 0), fl};
      mask = {2'b11, {XW{c == 0}}, 1'b1, {HW{ren}}, {XW{ren}},
              7'h7f};
      n_cmp++;
      if ((outs() & mask) !== (exp & mask)) begin
        n_bad++;
        $display("FAIL %s c=%0d got=%h want=%h", tag, c,
                 outs() & mask, exp & mask);
      end
      if (c == p) begin
        if (c >= 1 && c <= N + L) acc |= pb;
        m_sticky |= pb;
      end
    end
    m_wp = (m_wp + 1) % (1 << XW);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_wp = 0;
    m_sticky = 3'b000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (outs() !== RST_VEC) begin
      n_bad++;
      $display("FAIL reset_hold got=%h want=%h", outs(), RST_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (outs() !== RST_VEC) begin
      n_bad++;
      $display("FAIL reset_release got=%h want=%h", outs(), RST_VEC);
    end
    m_wp = 0;
    m_sticky = 3'b000;
  endtask

  task automatic test_single();
    test_pass(0, -1, 3'b000, 1'b0, "single");
  endtask

  task automatic test_random();
    int d, p;
    logic [2:0] pb;
    for (int i = 0; i < 20; i++) begin
      d  = int'($urandom_range(0, 4));
      p  = int'($urandom_range(0, N + L + 1 + d));
      pb = 3'($urandom_range(1, 7));
      test_pass(d, p, pb, 1'b0, "random");
    end
  endtask

  task automatic test_back_to_back();
    test_pass(10, -1, 3'b000, 1'b1, "bp_hold");
    test_pass(0, -1, 3'b000, 1'b1, "bp_accept");
    test_pass(0, -1, 3'b000, 1'b0, "b2b_next");
  endtask

  task automatic test_flags();
`ifdef FIR_EXC_STICKY_EN
    @(negedge clk);
    idle_inputs();
    overflow_i = 1'b1;
    m_sticky |= 3'b100;
    @(negedge clk);
    overflow_i = 1'b0;
    #1;
    n_cmp++;
    if ({overflow_o, underflow_o, invalid_o} !== m_sticky) begin
      n_bad++;
      $display("FAIL sticky_set got=%b want=%b",
               {overflow_o, underflow_o, invalid_o}, m_sticky);
    end
    test_pass(0, -1, 3'b000, 1'b0, "sticky_p1");
    test_pass(0, -1, 3'b000, 1'b0, "sticky_p2");
    @(negedge clk);
    idle_inputs();
    clr_flags_i = 1'b1;
    @(negedge clk);
    clr_flags_i = 1'b0;
    m_sticky = 3'b000;
    #1;
    n_cmp++;
    if ({overflow_o, underflow_o, invalid_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL sticky_clr got=%b want=000",
               {overflow_o, underflow_o, invalid_o});
    end
    @(negedge clk);
    clr_flags_i = 1'b1;
    overflow_i  = 1'b1;
    @(negedge clk);
    clr_flags_i = 1'b0;
    overflow_i  = 1'b0;
    m_sticky = 3'b100;
    #1;
    n_cmp++;
    if ({overflow_o, underflow_o, invalid_o} !== 3'b100) begin
      n_bad++;
      $display("FAIL sticky_set_wins got=%b want=100",
               {overflow_o, underflow_o, invalid_o});
    end
`else
    test_pass(0, N + 2, 3'b001, 1'b0, "flags_p1");
    test_pass(0, -1, 3'b000, 1'b0, "flags_p2");
`endif
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 65; i++)
      test_pass(0, -1, 3'b000, 1'b0, "wrap");
  endtask

  task automatic test_reset_mid_drain();
    for (int c = 0; c <= N + 2; c++) begin
      @(negedge clk);
      idle_inputs();
      s_valid_i = (c == 0);
      if (c == N + 2) rst = 1'b1;
    end
    #1;
    n_cmp++;
    if (outs() !== RST_VEC) begin
      n_bad++;
      $display("FAIL rst_mid_drain got=%h want=%h", outs(), RST_VEC);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (outs() !== RST_VEC) begin
      n_bad++;
      $display("FAIL rst_held got=%h want=%h", outs(), RST_VEC);
    end
    rst = 1'b0;
    m_wp = 0;
    m_sticky = 3'b000;
    test_pass(0, -1, 3'b000, 1'b0, "after_rst");
  endtask

  initial begin
    test_reset();
    test_single();
    test_random();
    test_back_to_back();
    test_flags();
    test_wrap();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
